// File: rtl/fir_param_engine.sv
// Runtime-configurable FIR engine: AXI-Lite configuration, AXI-Stream sample in/out, sequential MAC one tap per cycle.
// Optional build macro FIR_SATURATE_EN clamps the shifted result to the DATA_W signed range instead of wrapping.
module fir_param_engine #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_TAPS = 16,
    parameter int LEN_W    = 32
) (
    input  logic              axis_clk,
    input  logic              axis_rst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    input  logic              ss_tvalid,
    output logic              ss_tready,
    input  logic [DATA_W-1:0] ss_tdata,
    input  logic              ss_tlast,
    output logic              sm_tvalid,
    input  logic              sm_tready,
    output logic [DATA_W-1:0] sm_tdata,
    output logic              sm_tlast
);
    localparam int TAP_W = $clog2(MAX_TAPS);
    localparam int CNT_W = TAP_W + 1;
    localparam int ACC_W = 2 * DATA_W + TAP_W;

    localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(32'h0000_0000);
    localparam logic [ADDR_W-1:0] A_LEN      = ADDR_W'(32'h0000_0010);
    localparam logic [ADDR_W-1:0] A_TAPS     = ADDR_W'(32'h0000_0014);
    localparam logic [ADDR_W-1:0] A_SHIFT    = ADDR_W'(32'h0000_0018);
    localparam logic [ADDR_W-1:0] A_COEF     = ADDR_W'(32'h0000_0020);
    localparam logic [ADDR_W-1:0] A_COEF_END = ADDR_W'(32'h0000_0020 + 32'(4 * MAX_TAPS));

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN_IN = 3'd1,
        S_MAC    = 3'd2,
        S_OUT    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    function automatic logic coef_hit(input logic [ADDR_W-1:0] a);
        return (a >= A_COEF) && (a < A_COEF_END) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [TAP_W-1:0] coef_idx(input logic [ADDR_W-1:0] a);
        return TAP_W'((a - A_COEF) >> 2);
    endfunction

    function automatic logic [CNT_W-1:0] clamp_taps(input logic [DATA_W-1:0] v);
        if ((v == '0) || (v > DATA_W'(MAX_TAPS))) begin
            return CNT_W'(MAX_TAPS);
        end else begin
            return CNT_W'(v);
        end
    endfunction

    state_t state_q, state_d;

    logic              awready_q, arready_q, rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ap_done_q, tlast_err_q;
    logic [LEN_W-1:0]  data_length_q, count_q;
    logic [CNT_W-1:0]  tap_num_q, seen_q, k_q;
    logic [5:0]        out_shift_q;
    logic [DATA_W-1:0] coef_q [MAX_TAPS];
    logic [DATA_W-1:0] hist_q [MAX_TAPS];
    logic [TAP_W-1:0]  wr_ptr_q, newest_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [DATA_W-1:0] sm_tdata_q;
    logic              sm_tlast_q;

    logic              wr_fire_s, rd_fire_s, idle_s, cfg_wr_s, start_s;
    logic              last_in_s, mac_last_s;
    logic [DATA_W-1:0] rd_val_s;
    logic signed [DATA_W-1:0]   coef_s, hist_s;
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    acc_next_s;
    logic [DATA_W-1:0]          result_s;

    assign awready   = awready_q;
    assign wready    = awready_q;
    assign arready   = arready_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign ss_tready = (state_q == S_RUN_IN);
    assign sm_tvalid = (state_q == S_OUT);
    assign sm_tdata  = sm_tdata_q;
    assign sm_tlast  = sm_tlast_q;

    assign wr_fire_s  = awvalid & wvalid & awready_q;
    assign rd_fire_s  = arvalid & arready_q;
    assign idle_s     = (state_q == S_IDLE) || (state_q == S_DONE);
    assign cfg_wr_s   = wr_fire_s & idle_s;
    assign start_s    = wr_fire_s && (awaddr == A_CTRL) && wdata[0] && (state_q == S_IDLE);
    assign last_in_s  = (count_q == (data_length_q - LEN_W'(1)));
    assign mac_last_s = (k_q == (tap_num_q - CNT_W'(1)));

    // Register read mux; sampled at the address handshake so a same-cycle write is not yet visible
    always_comb begin
        rd_val_s = '0;
        case (araddr)
            A_CTRL:  rd_val_s[3:0] = {tlast_err_q, idle_s, ap_done_q, 1'b0};
            A_LEN:   rd_val_s = DATA_W'(data_length_q);
            A_TAPS:  rd_val_s = DATA_W'(tap_num_q);
            A_SHIFT: rd_val_s[5:0] = out_shift_q;
            default: begin
                if (coef_hit(araddr)) begin
                    rd_val_s = coef_q[coef_idx(araddr)];
                end else begin
                    rd_val_s = '0;
                end
            end
        endcase
    end

    // One MAC step; history slots not yet filled this run contribute zero
    always_comb begin
        coef_s = coef_q[k_q[TAP_W-1:0]];
        if (k_q < seen_q) begin
            hist_s = hist_q[newest_q - k_q[TAP_W-1:0]];
        end else begin
            hist_s = '0;
        end
        prod_s     = coef_s * hist_s;
        acc_next_s = acc_q + {{TAP_W{prod_s[2*DATA_W-1]}}, prod_s};
    end

`ifdef FIR_SATURATE_EN
    logic signed [ACC_W-1:0] shifted_s;

    // Clamp when the bits above the result sign are not a pure sign extension
    always_comb begin
        shifted_s = acc_next_s >>> out_shift_q;
        if ((&shifted_s[ACC_W-1:DATA_W-1]) || ~(|shifted_s[ACC_W-1:DATA_W-1])) begin
            result_s = shifted_s[DATA_W-1:0];
        end else if (shifted_s[ACC_W-1]) begin
            result_s = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            result_s = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign result_s = DATA_W'(acc_next_s >>> out_shift_q);
`endif

    // Control state register
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d = (data_length_q == '0) ? S_DONE : S_RUN_IN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN_IN: begin
                if (ss_tvalid) begin
                    state_d = S_MAC;
                end else begin
                    state_d = S_RUN_IN;
                end
            end
            S_MAC: begin
                if (mac_last_s) begin
                    state_d = S_OUT;
                end else begin
                    state_d = S_MAC;
                end
            end
            S_OUT: begin
                if (sm_tready) begin
                    state_d = ((count_q + LEN_W'(1)) == data_length_q) ? S_DONE : S_RUN_IN;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // AXI-Lite handshakes: write needs both channels; one read outstanding at a time
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= awvalid & wvalid & ~awready_q;
            arready_q <= arvalid & ~arready_q & ~rvalid_q;
            if (rd_fire_s) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val_s;
            end else if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Configuration registers, writable only while idle
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            data_length_q <= '0;
            tap_num_q     <= CNT_W'(1);
            out_shift_q   <= 6'd0;
            for (int i = 0; i < MAX_TAPS; i++) coef_q[i] <= '0;
        end else if (cfg_wr_s) begin
            if (awaddr == A_LEN) data_length_q <= LEN_W'(wdata);
            if (awaddr == A_TAPS) tap_num_q <= clamp_taps(wdata);
            if (awaddr == A_SHIFT) out_shift_q <= wdata[5:0];
            if (coef_hit(awaddr)) coef_q[coef_idx(awaddr)] <= wdata;
        end
    end

    // Sample history, MAC accumulator, output register and status flags
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            for (int i = 0; i < MAX_TAPS; i++) hist_q[i] <= '0;
            wr_ptr_q    <= '0;
            newest_q    <= '0;
            seen_q      <= '0;
            k_q         <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            sm_tdata_q  <= '0;
            sm_tlast_q  <= 1'b0;
            ap_done_q   <= 1'b0;
            tlast_err_q <= 1'b0;
        end else begin
            if (rd_fire_s && (araddr == A_CTRL)) begin
                ap_done_q   <= 1'b0;
                tlast_err_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_s) begin
                        count_q   <= '0;
                        seen_q    <= '0;
                        ap_done_q <= 1'b0;
                    end
                end
                S_RUN_IN: begin
                    if (ss_tvalid) begin
                        hist_q[wr_ptr_q] <= ss_tdata;
                        newest_q <= wr_ptr_q;
                        wr_ptr_q <= wr_ptr_q + TAP_W'(1);
                        if (seen_q != CNT_W'(MAX_TAPS)) seen_q <= seen_q + CNT_W'(1);
                        k_q   <= '0;
                        acc_q <= '0;
                        if (ss_tlast != last_in_s) tlast_err_q <= 1'b1;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_next_s;
                    k_q   <= k_q + CNT_W'(1);
                    if (mac_last_s) begin
                        sm_tdata_q <= result_s;
                        sm_tlast_q <= last_in_s;
                    end
                end
                S_OUT: begin
                    if (sm_tready) count_q <= count_q + LEN_W'(1);
                end
                S_DONE:  ap_done_q <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_param_engine.sv
// Scoreboard bench for fir_param_engine: directed stimulus pushes expected outputs, a monitor pops and compares.
module tb_fir_param_engine;
    logic        clk, rst;
    logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic        ss_tvalid, ss_tready, ss_tlast, sm_tvalid, sm_tready, sm_tlast;
    logic [31:0] ss_tdata, sm_tdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];

    fir_param_engine #(.ADDR_W(12), .DATA_W(32), .MAX_TAPS(16), .LEN_W(32)) dut (
        .axis_clk(clk), .axis_rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Monitor: every accepted output sample is checked against the scoreboard head
    always @(negedge clk) begin
        if (!rst && sm_tvalid && sm_tready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL stream_unexpected: got %h last %b expected none", sm_tdata, sm_tlast);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({sm_tlast, sm_tdata} !== e) begin
                    n_bad++;
                    $display("FAIL stream: got last=%b data=%h expected last=%b data=%h",
                             sm_tlast, sm_tdata, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
        int i;
        @(negedge clk);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d;
        i = 0;
        while (!awready && i < 100) begin @(negedge clk); i++; end
        if (!awready) timeout("axi_write");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
        int i;
        @(negedge clk);
        arvalid = 1'b1; araddr = a;
        i = 0;
        while (!arready && i < 100) begin @(negedge clk); i++; end
        if (!arready) timeout("axi_read_addr");
        @(posedge clk); #1;
        arvalid = 1'b0;
        i = 0;
        do begin @(negedge clk); i++; end while (!rvalid && i < 100);
        if (!rvalid) timeout("axi_read_data");
        d = rdata;
        @(posedge clk); #1;
    endtask

    task automatic read_check(input string name, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(a, d);
        check(name, d, exp);
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int i;
        @(negedge clk);
        ss_tvalid = 1'b1; ss_tdata = d; ss_tlast = last;
        i = 0;
        while (!ss_tready && i < 2000) begin @(negedge clk); i++; end
        if (!ss_tready) timeout("ss_handshake");
        @(posedge clk); #1;
        ss_tvalid = 1'b0; ss_tlast = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 20000) begin @(negedge clk); i++; end
        if (exp_q.size() != 0) begin
            timeout("drain");
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic cfg(input int taps, input int shift, input int len);
        axi_write(12'h014, 32'(taps));
        axi_write(12'h018, 32'(shift));
        axi_write(12'h010, 32'(len));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c11[11];
        int x[600];
        int acc, n, lat;
        logic [31:0] held;
        c11 = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

        rst = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rready = 1'b1;
        awaddr = 12'h000; araddr = 12'h000; wdata = 32'h0;
        ss_tvalid = 1'b0; ss_tdata = 32'h0; ss_tlast = 1'b0; sm_tready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sm_tvalid", {31'b0, sm_tvalid}, 32'h0);
        check("rst_ss_tready", {31'b0, ss_tready}, 32'h0);
        rst = 1'b0;
        read_check("rst_ctrl", 12'h000, 32'h4);
        read_check("rst_tap_num", 12'h014, 32'h1);
        read_check("rst_coef0", 12'h020, 32'h0);

        // tap_num=1, coef 3, shift 1; output held while sm_tready low
        axi_write(12'h020, 32'd3);
        cfg(1, 1, 2);
        sm_tready = 1'b0;
        axi_write(12'h000, 32'h1);
        exp_q.push_back({1'b0, 32'd6});
        exp_q.push_back({1'b1, 32'hFFFF_FFF8});
        send(32'd4, 1'b0);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!sm_tvalid && lat < 50);
        check("latency", 32'(lat), 32'd2);
        held = sm_tdata;
        repeat (5) @(negedge clk);
        check("hold_valid", {31'b0, sm_tvalid}, 32'h1);
        check("hold_data", sm_tdata, held);
        @(posedge clk); #1;
        sm_tready = 1'b1;
        send(32'hFFFF_FFFB, 1'b1);
        drain();
        read_check("done_ctrl", 12'h000, 32'h6);
        read_check("done_ctrl_cleared", 12'h000, 32'h4);

        // misplaced tlast on sample 3 of 5
        axi_write(12'h020, 32'd1);
        cfg(1, 0, 5);
        axi_write(12'h000, 32'h1);
        for (int i = 0; i < 5; i++) exp_q.push_back({(i == 4), 32'(10 * (i + 1))});
        for (int i = 0; i < 5; i++) send(32'(10 * (i + 1)), (i == 3));
        drain();
        read_check("tlast_err_ctrl", 12'h000, 32'hE);
        read_check("tlast_err_cleared", 12'h000, 32'h4);

        // 11-tap filter over a 600-sample triangle
        for (int k = 0; k < 11; k++) axi_write(12'(32'h20 + 4 * k), 32'(c11[k]));
        cfg(11, 0, 600);
        for (int i = 0; i < 600; i++) x[i] = (((i % 100) < 50) ? (i % 100) : (100 - (i % 100))) - 25;
        for (int i = 0; i < 600; i++) begin
            acc = 0;
            for (int k = 0; k < 11; k++) if (i - k >= 0) acc += c11[k] * x[i - k];
            exp_q.push_back({(i == 599), 32'(acc)});
        end
        axi_write(12'h000, 32'h1);
        for (int i = 0; i < 600; i++) send(32'(x[i]), (i == 599));
        drain();
        read_check("fir11_ctrl", 12'h000, 32'h6);

        // tap_num clamp, writes while busy dropped
        axi_write(12'h014, 32'd20);
        read_check("tap_clamp", 12'h014, 32'd16);
        axi_write(12'h020, 32'd7);
        cfg(1, 0, 1);
        axi_write(12'h000, 32'h1);
        axi_write(12'h020, 32'd99);
        axi_write(12'h010, 32'd9);
        read_check("busy_ctrl", 12'h000, 32'h0);
        read_check("busy_coef0", 12'h020, 32'd7);
        read_check("busy_len", 12'h010, 32'd1);
        exp_q.push_back({1'b1, 32'd21});
        send(32'd3, 1'b1);
        drain();
        read_check("busy_done_ctrl", 12'h000, 32'h6);

        // data_length 0 finishes without stream traffic
        axi_write(12'h010, 32'd0);
        axi_write(12'h000, 32'h1);
        repeat (4) @(negedge clk);
        check("len0_ss_tready", {31'b0, ss_tready}, 32'h0);
        read_check("len0_ctrl", 12'h000, 32'h6);

        // overflow: saturate or wrap depending on build
        axi_write(12'h020, 32'h4000_0000);
        cfg(1, 0, 1);
        axi_write(12'h000, 32'h1);
`ifdef FIR_SATURATE_EN
        exp_q.push_back({1'b1, 32'h7FFF_FFFF});
`else
        exp_q.push_back({1'b1, 32'h0000_0000});
`endif
        send(32'd4, 1'b1);
        drain();

        // reset in the middle of MAC
        cfg(16, 0, 3);
        axi_write(12'h000, 32'h1);
        send(32'd5, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sm_tvalid", {31'b0, sm_tvalid}, 32'h0);
        rst = 1'b0;
        read_check("midrst_ctrl", 12'h000, 32'h4);
        read_check("midrst_coef0", 12'h020, 32'h0);
        read_check("midrst_tap_num", 12'h014, 32'h1);
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
